dma_rd_arb: RTL and testbench

Round-robin arbiter that shares one burst read master port between N read-DMA channels. It tracks outstanding bursts in issue order and steers returned data beats back to the channel that issued them. It sits between the per-channel read-DMA engines and the single system read port.

---
 rtl/dma_rd_arb_pkg.sv | 24 ++
 rtl/dma_rd_arb_tagq.sv | 58 +++++
 rtl/dma_rd_arb.sv | 146 ++++++++++++++
 tb/tb_dma_rd_arb.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_rd_arb_pkg.sv
`default_nettype none
// ============================================================================
// dma_rd_arb_pkg : shared constants and types for the DMA read arbiter
// Revision: 1.0
// ============================================================================
package dma_rd_arb_pkg;

    // Channel-id width; a single bit is kept even for N=2 so the id never vanishes.
    function automatic int cidw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Tag layout in the queue: {id, len}, id in the upper bits.
    function automatic int tag_w(input int n, input int bl);
        return cidw(n) + bl;
    endfunction

    typedef enum logic [0:0] {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/dma_rd_arb_tagq.sv
`default_nettype none
// ============================================================================
// dma_rd_arb_tagq : fall-through FIFO holding outstanding burst tags
// Revision: 1.0
// ============================================================================
module dma_rd_arb_tagq #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == (PW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_rd_arb.sv
`default_nettype none
// ============================================================================
// dma_rd_arb : round-robin arbiter sharing one burst read port among N channels
// Revision: 1.0
// ============================================================================
module dma_rd_arb
    import dma_rd_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int DW = 64,
    parameter int BL = 4,
    parameter int OD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    m_rval,
    output logic [N-1:0]    m_rrdy,
    input  logic [N*BL-1:0] m_rlen,
    input  logic [N*AW-1:0] m_raddr,
    output logic [DW-1:0]   m_rdata,
    output logic [N-1:0]    m_rdval,
    input  logic            s_rrdy,
    output logic            s_rval,
    output logic [BL-1:0]   s_rlen,
    output logic [AW-1:0]   s_raddr,
    input  logic [DW-1:0]   s_rdata,
    input  logic            s_rdval,
    output logic            busy,
    output logic            err
);
    localparam int CIDW = cidw(N);
    localparam int TW   = tag_w(N, BL);

    arb_state_e      r_state;
    logic [CIDW-1:0] r_ptr;
    logic [CIDW-1:0] r_sel;
    logic [CIDW-1:0] w_arb_sel;
    logic [CIDW-1:0] w_sel;
    logic [CIDW-1:0] w_next;
    logic            w_found;
    logic            w_acc;
    logic [TW-1:0]   w_head;
    logic [CIDW-1:0] w_head_id;
    logic [BL-1:0]   w_head_len;
    logic            w_full;
    logic            w_empty;
    logic            w_beat;
    logic            w_pop;
    logic [BL-1:0]   r_beat_cnt;
    logic            r_err;

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        w_arb_sel = r_ptr;
        w_found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && m_rval[(int'(r_ptr) + k) % N]) begin
                w_arb_sel = CIDW'((int'(r_ptr) + k) % N);
                w_found   = 1'b1;
            end
        end
    end

    assign w_sel   = (r_state == ARB_LOCKED) ? r_sel : w_arb_sel;
    assign w_next  = (w_sel == CIDW'(N-1)) ? '0 : w_sel + 1'b1;
    assign s_rval  = m_rval[w_sel] & ~w_full;
    assign s_rlen  = m_rlen[w_sel*BL +: BL];
    assign s_raddr = m_raddr[w_sel*AW +: AW];
    assign w_acc   = s_rval & s_rrdy;

    always_comb begin
        m_rrdy        = '0;
        m_rrdy[w_sel] = s_rrdy & ~w_full;
    end

    // A stalled command pins the selection so the bus sees a stable request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_OPEN;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ARB_OPEN: begin
                    if (s_rval && !s_rrdy) begin
                        r_state <= ARB_LOCKED;
                        r_sel   <= w_sel;
                    end else if (w_acc) begin
                        r_ptr <= w_next;
                    end
                end
                ARB_LOCKED: begin
                    if (w_acc) begin
                        r_state <= ARB_OPEN;
                        r_ptr   <= w_next;
                    end
                end
                default: r_state <= ARB_OPEN;
            endcase
        end
    end

    dma_rd_arb_tagq #(
        .W     (TW),
        .DEPTH (OD)
    ) u_tagq (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_acc),
        .i_din   ({w_sel, s_rlen}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_id  = w_head[TW-1:BL];
    assign w_head_len = w_head[BL-1:0];
    assign w_beat     = s_rdval & ~w_empty;
    assign w_pop      = w_beat & (r_beat_cnt == w_head_len);
    assign m_rdata    = s_rdata;
    assign busy       = ~w_empty;
    assign err        = r_err;

    always_comb begin
        m_rdval = '0;
        if (w_beat) m_rdval[w_head_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_pop) begin
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (s_rdval && w_empty) r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_rd_arb.sv
`default_nettype none
// ============================================================================
// tb_dma_rd_arb : self-checking bench for dma_rd_arb (N=2, OD=4)
// Revision: 1.0
// ============================================================================
module tb_dma_rd_arb;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BL = 4;
    localparam int OD = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    m_rval;
    logic [N-1:0]    m_rrdy;
    logic [N*BL-1:0] m_rlen;
    logic [N*AW-1:0] m_raddr;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_rdval;
    logic            s_rrdy;
    logic            s_rval;
    logic [BL-1:0]   s_rlen;
    logic [AW-1:0]   s_raddr;
    logic [DW-1:0]   s_rdata;
    logic            s_rdval;
    logic            busy;
    logic            err;

    dma_rd_arb #(.N(N), .AW(AW), .DW(DW), .BL(BL), .OD(OD)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_rval(m_rval), .m_rrdy(m_rrdy), .m_rlen(m_rlen), .m_raddr(m_raddr),
        .m_rdata(m_rdata), .m_rdval(m_rdval),
        .s_rrdy(s_rrdy), .s_rval(s_rval), .s_rlen(s_rlen), .s_raddr(s_raddr),
        .s_rdata(s_rdata), .s_rdval(s_rdval),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: outstanding bursts in issue order plus arbitration state.
    int       md_id[$];
    int       md_len[$];
    int       md_ptr;
    int       md_pend;
    int       md_beat;
    bit       md_err;
    logic [N-1:0] last_acc;

    typedef struct {
        logic [1:0]  rval;
        logic        rrdy;
        logic        rdval;
        logic        e_sval;
        logic [1:0]  e_rrdy;
        logic [1:0]  e_rdval;
        logic        e_busy;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int i, input logic [AW-1:0] a, input logic [BL-1:0] l);
        m_raddr[i*AW +: AW] = a;
        m_rlen[i*BL +: BL]  = l;
    endtask

    function automatic int model_sel();
        if (md_pend >= 0) return md_pend;
        for (int k = 0; k < N; k++) begin
            if (m_rval[(md_ptr + k) % N]) return (md_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_clear();
        md_id.delete();
        md_len.delete();
        md_ptr  = 0;
        md_pend = -1;
        md_beat = 0;
        md_err  = 0;
    endtask

    // Check outputs against the model for the current inputs, then advance one clock.
    task automatic step();
        int sel;
        int pre_n;
        bit full;
        bit e_sval;
        logic [N-1:0] e_rrdy;
        logic [N-1:0] e_rdval;
        #1;
        sel    = model_sel();
        pre_n  = md_id.size();
        full   = (pre_n == OD);
        e_sval = (sel >= 0) && m_rval[sel] && !full;
        e_rrdy = '0;
        if (sel >= 0 && s_rrdy && !full) e_rrdy[sel] = 1'b1;
        e_rdval = '0;
        if (s_rdval && pre_n > 0) e_rdval[md_id[0]] = 1'b1;
        chk("s_rval", 64'(s_rval), 64'(e_sval));
        if (m_rval != '0) chk("m_rrdy", 64'(m_rrdy), 64'(e_rrdy));
        chk("m_rdval", 64'(m_rdval), 64'(e_rdval));
        chk("busy", 64'(busy), 64'(pre_n != 0));
        chk("err", 64'(err), 64'(md_err));
        chk("m_rdata", m_rdata, s_rdata);
        if (e_sval) begin
            chk("s_raddr", 64'(s_raddr), 64'(m_raddr[sel*AW +: AW]));
            chk("s_rlen", 64'(s_rlen), 64'(m_rlen[sel*BL +: BL]));
        end
        last_acc = '0;
        if (e_sval && s_rrdy) last_acc[sel] = 1'b1;
        @(posedge clk);
        if (s_rdval && pre_n > 0) begin
            if (md_beat == md_len[0]) begin
                void'(md_id.pop_front());
                void'(md_len.pop_front());
                md_beat = 0;
            end else begin
                md_beat++;
            end
        end
        if (s_rdval && pre_n == 0) md_err = 1;
        if (e_sval && s_rrdy) begin
            md_id.push_back(sel);
            md_len.push_back(int'(m_rlen[sel*BL +: BL]));
            md_ptr  = (sel + 1) % N;
            md_pend = -1;
        end else if (e_sval) begin
            md_pend = sel;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        m_rval  = '0;
        m_rlen  = '0;
        m_raddr = '0;
        s_rrdy  = 1'b0;
        s_rdval = 1'b0;
        s_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst s_rval", 64'(s_rval), 64'd0);
        chk("rst m_rrdy", 64'(m_rrdy), 64'd0);
        chk("rst m_rdval", 64'(m_rdval), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        rst_n = 1'b1;
        model_clear();
    endtask

    logic [1:0] route [6];

    initial begin
        // Alternating grants with rlen=0, queue fill, grant after a pop, drain.
        tbl[0]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 32'h1000};
        tbl[1]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 32'h2000};
        tbl[2]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 32'h1000};
        tbl[3]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 32'h2000};
        tbl[4]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0};
        tbl[5]  = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 32'h0};
        tbl[6]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 32'h1000};
        tbl[7]  = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 32'h0};
        tbl[8]  = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 32'h0};
        tbl[9]  = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 32'h0};
        tbl[10] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 32'h0};
        tbl[11] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0};
        route = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};

        model_clear();
        do_reset();

        set_ch(0, 32'h1000, 4'd0);
        set_ch(1, 32'h2000, 4'd0);
        for (int r = 0; r < 12; r++) begin
            m_rval  = tbl[r].rval;
            s_rrdy  = tbl[r].rrdy;
            s_rdval = tbl[r].rdval;
            s_rdata = {$urandom, $urandom};
            #1;
            chk($sformatf("tbl%0d s_rval", r), 64'(s_rval), 64'(tbl[r].e_sval));
            if (tbl[r].rval != 2'b00) chk($sformatf("tbl%0d m_rrdy", r), 64'(m_rrdy), 64'(tbl[r].e_rrdy));
            chk($sformatf("tbl%0d m_rdval", r), 64'(m_rdval), 64'(tbl[r].e_rdval));
            chk($sformatf("tbl%0d busy", r), 64'(busy), 64'(tbl[r].e_busy));
            if (tbl[r].e_sval) chk($sformatf("tbl%0d s_raddr", r), 64'(s_raddr), 64'(tbl[r].e_addr));
            step();
        end

        // Single 4-beat burst from channel 0.
        do_reset();
        set_ch(0, 32'h1000, 4'd3);
        m_rval = 2'b01;
        s_rrdy = 1'b1;
        #1;
        chk("single s_raddr", 64'(s_raddr), 64'h1000);
        chk("single s_rlen", 64'(s_rlen), 64'd3);
        step();
        m_rval = 2'b00;
        s_rrdy = 1'b0;
        step();
        for (int b = 0; b < 4; b++) begin
            s_rdval = 1'b1;
            s_rdata = {$urandom, $urandom};
            #1;
            chk("single rdval", 64'(m_rdval), 64'h1);
            chk("single rdata", m_rdata, s_rdata);
            step();
        end
        s_rdval = 1'b0;
        #1;
        chk("single busy end", 64'(busy), 64'd0);
        step();

        // Lock: ch0 stalls while ch1 would win by round-robin.
        do_reset();
        set_ch(0, 32'h1000, 4'd0);
        set_ch(1, 32'h2000, 4'd0);
        m_rval = 2'b01;
        s_rrdy = 1'b1;
        step();
        set_ch(0, 32'h1100, 4'd0);
        s_rrdy = 1'b0;
        step();
        m_rval = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("lock s_raddr", 64'(s_raddr), 64'h1100);
            step();
        end
        s_rrdy = 1'b1;
        #1;
        chk("lock grant", 64'(m_rrdy), 64'h1);
        chk("lock s_raddr", 64'(s_raddr), 64'h1100);
        step();
        m_rval = 2'b10;
        #1;
        chk("after lock grant", 64'(m_rrdy), 64'h2);
        step();
        m_rval  = 2'b00;
        s_rrdy  = 1'b0;
        s_rdval = 1'b1;
        repeat (3) step();
        s_rdval = 1'b0;
        step();

        // Interleaved lengths: 2 + 3 + 1 beats returned in issue order.
        do_reset();
        set_ch(0, 32'h3000, 4'd1);
        set_ch(1, 32'h4000, 4'd2);
        m_rval = 2'b11;
        s_rrdy = 1'b1;
        step();
        set_ch(0, 32'h3100, 4'd0);
        step();
        m_rval = 2'b01;
        step();
        m_rval = 2'b00;
        s_rrdy = 1'b0;
        for (int b = 0; b < 6; b++) begin
            s_rdval = 1'b1;
            s_rdata = {$urandom, $urandom};
            #1;
            chk($sformatf("route beat%0d", b), 64'(m_rdval), 64'(route[b]));
            step();
        end
        s_rdval = 1'b0;
        #1;
        chk("route busy end", 64'(busy), 64'd0);
        step();

        // Randomised traffic; commands stay asserted and stable until accepted.
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!m_rval[i] && $urandom_range(0, 2) == 0) begin
                    m_rval[i] = 1'b1;
                    set_ch(i, $urandom, 4'($urandom_range(0, 3)));
                end
            end
            s_rrdy  = ($urandom_range(0, 3) != 0);
            s_rdval = (md_id.size() > 0) && ($urandom_range(0, 1) == 1);
            s_rdata = {$urandom, $urandom};
            step();
            m_rval = m_rval & ~last_acc;
        end

        // Stray beat while idle sets a sticky error; reset clears it.
        do_reset();
        s_rdval = 1'b1;
        #1;
        chk("idle beat rdval", 64'(m_rdval), 64'd0);
        step();
        s_rdval = 1'b0;
        #1;
        chk("err set", 64'(err), 64'd1);
        repeat (3) step();
        chk("err sticky", 64'(err), 64'd1);
        set_ch(0, 32'h5000, 4'd2);
        m_rval = 2'b01;
        s_rrdy = 1'b1;
        step();
        m_rval = 2'b00;
        s_rrdy = 1'b0;
        step();
        do_reset();
        s_rdval = 1'b1;
        step();
        s_rdval = 1'b0;
        #1;
        chk("late beat err", 64'(err), 64'd1);
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
